// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes two active-low board keys and an 8-bit switch bank,
// producing clean key levels, one-cycle rising-edge strobes and an operand frozen during Execute.
// Optional macro INPUT_CONDITIONER_DEBOUNCE_EN adds a per-key debounce counter after the synchronizer.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ExecuteRaw_n,
  input  logic       ClearA_loadBRaw_n,
  input  logic [7:0] SwRaw,
  output logic       Execute,
  output logic       ClearA_loadB,
  output logic       ExecutePulse,
  output logic       ClearPulse,
  output logic [7:0] mand
);

  // Reject illegal parameter values at elaboration
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("input_conditioner: SYNC_STAGES must be in 2..4");
  end
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be in 2..2^20");
  end

  // Key index 0 is Execute, index 1 is ClearA_loadB.
  logic [1:0]             key_raw;
  logic [SYNC_STAGES-1:0] key_sync_q [2];
  logic [7:0]             sw_sync_q  [SYNC_STAGES];
  logic [1:0]             key_now;    // synchronized key level
  logic [1:0]             key_next;   // value key_now takes after the next edge
  logic [1:0]             level_q;    // conditioned key level driven on the outputs
  logic [1:0]             level_d;    // level_q after the next edge
  logic [1:0]             pulse_q;
  logic [7:0]             mand_q;
  logic [7:0]             mand_d;

  // Keys are inverted ahead of the first flop so the released state is 0
  assign key_raw = {~ClearA_loadBRaw_n, ~ExecuteRaw_n};

  // Synchronizer chains for both keys and the switch bank
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 2; k++) key_sync_q[k] <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sw_sync_q[s] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) key_sync_q[k] <= {key_sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
      sw_sync_q[0] <= SwRaw;
      for (int s = 1; s < SYNC_STAGES; s++) sw_sync_q[s] <= sw_sync_q[s-1];
    end
  end

  // Tap the last synchronizer stage and the stage feeding it
  always_comb begin
    key_now  = '0;
    key_next = '0;
    for (int k = 0; k < 2; k++) begin
      key_now[k]  = key_sync_q[k][SYNC_STAGES-1];
      key_next[k] = key_sync_q[k][SYNC_STAGES-2];
    end
  end

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, COUNTING} db_state_e;

  db_state_e        state_q [2];
  logic [CNT_W-1:0] cnt_q   [2];

  // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES
  always_comb begin
    level_d = level_q;
    for (int k = 0; k < 2; k++) begin
      if (state_q[k] == COUNTING && key_now[k] != level_q[k] && cnt_q[k] == CNT_LAST)
        level_d[k] = ~level_q[k];
    end
  end

  // Per-key debounce FSM; a bounce back to the current level drops the count
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
      level_q <= '0;
      pulse_q <= '0;
    end else begin
      level_q <= level_d;
      pulse_q <= level_d & ~level_q;
      for (int k = 0; k < 2; k++) begin
        case (state_q[k])
          IDLE: begin
            if (key_now[k] != level_q[k]) begin
              state_q[k] <= COUNTING;
              cnt_q[k]   <= CNT_W'(1);
            end
          end
          COUNTING: begin
            if (key_now[k] == level_q[k] || cnt_q[k] == CNT_LAST) begin
              state_q[k] <= IDLE;
              cnt_q[k]   <= '0;
            end else begin
              cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
          end
          default: begin
            state_q[k] <= IDLE;
            cnt_q[k]   <= '0;
          end
        endcase
      end
    end
  end
`else
  // The synchronized level is the conditioned level
  assign level_q = key_now;
  assign level_d = key_next;

  // Strobe when the synchronized level is about to rise
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) pulse_q <= '0;
    else       pulse_q <= key_next & ~key_now;
  end
`endif

  // Freeze the operand on every edge that leaves Execute high, including the rising one
  always_comb begin
    mand_d = level_d[0] ? mand_q : sw_sync_q[SYNC_STAGES-1];
  end

  // Operand register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) mand_q <= '0;
    else       mand_q <= mand_d;
  end

  assign Execute      = level_q[0];
  assign ClearA_loadB = level_q[1];
  assign ExecutePulse = pulse_q[0];
  assign ClearPulse   = pulse_q[1];
  assign mand         = mand_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: table of key/switch vectors checked through a scoreboard queue,
// plus hand sequences for bounce rejection and asynchronous reset mid-debounce.
// Expectations follow SYNC_STAGES=2 and DEBOUNCE_CYCLES=4 with or without INPUT_CONDITIONER_DEBOUNCE_EN.
module tb_input_conditioner;

`ifdef INPUT_CONDITIONER_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = 2 + 4;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 2;
`endif
  localparam int NV = 21;

  logic       Clk;
  logic       Reset;
  logic       ExecuteRaw_n;
  logic       ClearA_loadBRaw_n;
  logic [7:0] SwRaw;
  logic       Execute;
  logic       ClearA_loadB;
  logic       ExecutePulse;
  logic       ClearPulse;
  logic [7:0] mand;

  int total = 0;
  int bad   = 0;

  input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .ExecuteRaw_n     (ExecuteRaw_n),
    .ClearA_loadBRaw_n(ClearA_loadBRaw_n),
    .SwRaw            (SwRaw),
    .Execute          (Execute),
    .ClearA_loadB     (ClearA_loadB),
    .ExecutePulse     (ExecutePulse),
    .ClearPulse       (ClearPulse),
    .mand             (mand)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

  typedef struct {
    logic        e_n;
    logic        c_n;
    logic [7:0]  sw;
    int          edges;
    logic [11:0] outs;   // {Execute, ClearA_loadB, ExecutePulse, ClearPulse, mand}
    logic [11:0] mask;
  } vec_t;

  vec_t vec [NV];
  vec_t exp_q [$];

  function automatic vec_t mk(input logic e_n, input logic c_n, input logic [7:0] sw,
                              input int edges, input logic [3:0] flags,
                              input logic [7:0] m, input logic chk_mand);
    vec_t v;
    v.e_n   = e_n;
    v.c_n   = c_n;
    v.sw    = sw;
    v.edges = edges;
    v.outs  = {flags, m};
    v.mask  = chk_mand ? 12'hFFF : 12'hF00;
    return v;
  endfunction

  function automatic logic [11:0] dut_outs();
    return {Execute, ClearA_loadB, ExecutePulse, ClearPulse, mand};
  endfunction

  task automatic check(input string name, input logic [11:0] act,
                       input logic [11:0] want, input logic [11:0] mask);
    total++;
    if ((act & mask) !== (want & mask)) begin
      bad++;
      $display("FAIL %s: got %h expected %h (mask %h)", name, act & mask, want & mask, mask);
    end
  endtask

  // Bounce schedule: raw key pressed on every sampling edge except edge 4
  function automatic bit pressed(input int s);
    return (s >= 1) && (s != 4);
  endfunction

  initial begin
    vec_t        v;
    logic        e_lvl;
    logic        e_pls;

    vec[0]  = mk(1, 1, 8'hC5, 2,       4'b0000, 8'h00, 1);
    vec[1]  = mk(1, 1, 8'hC5, 1,       4'b0000, 8'hC5, 1);
    vec[2]  = mk(0, 1, 8'hC5, LAT - 1, 4'b0000, 8'hC5, 1);
    vec[3]  = mk(0, 1, 8'hC5, 1,       4'b1010, 8'hC5, 1);
    vec[4]  = mk(0, 1, 8'hC5, 1,       4'b1000, 8'hC5, 1);
    vec[5]  = mk(0, 1, 8'h3A, 6,       4'b1000, 8'hC5, 1);
    vec[6]  = mk(1, 1, 8'h3A, LAT - 1, 4'b1000, 8'hC5, 1);
    vec[7]  = mk(1, 1, 8'h3A, 1,       4'b0000, 8'h00, 0);
    vec[8]  = mk(1, 1, 8'h3A, 3,       4'b0000, 8'h3A, 1);
    vec[9]  = mk(1, 0, 8'h3A, LAT - 1, 4'b0000, 8'h3A, 1);
    vec[10] = mk(1, 0, 8'h3A, 1,       4'b0101, 8'h3A, 1);
    vec[11] = mk(1, 0, 8'h3A, 1,       4'b0100, 8'h3A, 1);
    vec[12] = mk(1, 1, 8'h5C, LAT - 1, 4'b0100, 8'h00, 0);
    vec[13] = mk(1, 1, 8'h5C, 1,       4'b0000, 8'h00, 0);
    vec[14] = mk(1, 1, 8'h5C, 3,       4'b0000, 8'h5C, 1);
    vec[15] = mk(0, 0, 8'h5C, LAT - 1, 4'b0000, 8'h5C, 1);
    vec[16] = mk(0, 0, 8'h5C, 1,       4'b1111, 8'h5C, 1);
    vec[17] = mk(0, 0, 8'h5C, 1,       4'b1100, 8'h5C, 1);
    vec[18] = mk(1, 1, 8'h5C, LAT - 1, 4'b1100, 8'h5C, 1);
    vec[19] = mk(1, 1, 8'h5C, 1,       4'b0000, 8'h5C, 1);
    vec[20] = mk(1, 1, 8'h5C, LAT + 2, 4'b0000, 8'h5C, 1);

    // Reset with keys released, then with keys pressed while reset is held
    Reset             = 1'b1;
    ExecuteRaw_n      = 1'b1;
    ClearA_loadBRaw_n = 1'b1;
    SwRaw             = 8'h00;
    @(negedge Clk);
    check("reset_state", dut_outs(), 12'h000, 12'hFFF);
    ExecuteRaw_n      = 1'b0;
    ClearA_loadBRaw_n = 1'b0;
    SwRaw             = 8'hFF;
    repeat (3) @(negedge Clk);
    check("reset_hold", dut_outs(), 12'h000, 12'hFFF);
    ExecuteRaw_n      = 1'b1;
    ClearA_loadBRaw_n = 1'b1;
    SwRaw             = 8'h00;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    // Table vectors through the scoreboard
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vec[i]);
      ExecuteRaw_n      = vec[i].e_n;
      ClearA_loadBRaw_n = vec[i].c_n;
      SwRaw             = vec[i].sw;
      repeat (vec[i].edges) @(negedge Clk);
      v = exp_q.pop_front();
      check($sformatf("vec%0d", i), dut_outs(), v.outs, v.mask);
    end

    // Bounce: low 3 samples, high 1, then low and held
    for (int e = 1; e <= 10; e++) begin
      ExecuteRaw_n = (e == 4) ? 1'b1 : 1'b0;
      @(negedge Clk);
      if (DEB) begin
        e_lvl = (e >= 10);
        e_pls = (e == 10);
      end else begin
        e_lvl = pressed(e - 1);
        e_pls = pressed(e - 1) && !pressed(e - 2);
      end
      check($sformatf("bounce_e%0d", e), dut_outs(), {e_lvl, 1'b0, e_pls, 1'b0, 8'h00}, 12'hF00);
    end
    ExecuteRaw_n = 1'b1;
    repeat (LAT + 2) @(negedge Clk);
    check("bounce_release", dut_outs(), 12'h000, 12'hF00);

    // Asynchronous reset with the key held partway through the debounce count
    ExecuteRaw_n = 1'b0;
    SwRaw        = 8'hA5;
    repeat (5) @(negedge Clk);
    #2 Reset = 1'b1;
    #1 check("async_reset", dut_outs(), 12'h000, 12'hFFF);
    #1 Reset = 1'b0;
    for (int e = 1; e <= LAT + 1; e++) begin
      @(negedge Clk);
      check($sformatf("post_reset_e%0d", e), dut_outs(),
            {(e >= LAT), 1'b0, (e == LAT), 1'b0, 8'h00}, 12'hF00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameters SHALL be:
  - SYNC_STAGES, default 2, synchronizer flop depth (legal values 2..4).
  - DEBOUNCE_CYCLES, default 500000, stable cycles required before a button level is accepted (legal values 2..2^20).
REQ-002 Ports SHALL be:
  - Clk  in  1  sole clock.
  - Reset  in  1  asynchronous, active-high reset.
  - ExecuteRaw_n  in  1  raw board key, active-low.
  - ClearA_loadBRaw_n  in  1  raw board key, active-low.
  - SwRaw  in  8  raw operand switches.
  - Execute  out  1  conditioned level, active-high.
  - ClearA_loadB  out  1  conditioned level, active-high.
  - ExecutePulse  out  1  one-cycle strobe on the Execute rising edge.
  - ClearPulse  out  1  one-cycle strobe on the ClearA_loadB rising edge.
  - mand  out  8  synchronized operand, frozen during Execute.

Function
REQ-003 Each raw input bit SHALL pass through SYNC_STAGES flops; keys SHALL be inverted before the first flop.
REQ-004 Each key SHALL have an independent debounce counter, with states IDLE (sync==level) and COUNTING (sync!=level).
REQ-005 In COUNTING, the counter SHALL increment by 1 per cycle while sync differs from the output level.
REQ-006 The counter SHALL clear and the key SHALL return to IDLE in the cycle that sync equals the output level again; a bounce shorter than DEBOUNCE_CYCLES SHALL leave the output unchanged.
REQ-007 The output level SHALL toggle, and the counter SHALL clear, in the cycle the counter would reach DEBOUNCE_CYCLES.
REQ-008 A clean raw edge held stable SHALL appear on Execute/ClearA_loadB exactly SYNC_STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-009 The counter width SHALL be ceil(log2(DEBOUNCE_CYCLES+1)), and the counter SHALL never wrap.
REQ-010 ExecutePulse SHALL be high for exactly one cycle, coincident with the first cycle Execute is 1.
REQ-011 ClearPulse SHALL follow the same rule relative to ClearA_loadB.
REQ-012 Releasing a key SHALL produce no pulse.
REQ-013 Both keys SHALL be processed independently, with simultaneous presses yielding simultaneous levels and pulses.
REQ-014 mand SHALL load the synchronized switch value every cycle while Execute is 0.
REQ-015 mand SHALL hold its value in every cycle that Execute is 1, including the first, so the operand is stable for a full multiply.
REQ-016 Switches SHALL NOT be debounced; their latency SHALL be SYNC_STAGES+1 edges.

Reset
REQ-017 While Reset is high, all outputs SHALL be 0, all counters 0, all key states IDLE, and all synchronizer flops at the released value (key sync 0, switch sync 0).
REQ-018 Reset SHALL act immediately, without a clock, and SHALL abort any in-progress debounce with no pulse emitted.
REQ-019 After Reset deasserts, a key that is already held SHALL be treated as a new press: full latency applies and a pulse is emitted.

Configuration
REQ-020 With the macro INPUT_CONDITIONER_DEBOUNCE_EN defined, the debounce counters of REQ-004..REQ-009 SHALL be present.
REQ-021 Without INPUT_CONDITIONER_DEBOUNCE_EN, Execute and ClearA_loadB SHALL equal the synchronized key levels directly, with latency SYNC_STAGES edges.
REQ-022 Without INPUT_CONDITIONER_DEBOUNCE_EN, DEBOUNCE_CYCLES SHALL be ignored, no counter logic SHALL be synthesized, and pulse and mand rules SHALL be unchanged.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, debounce enabled unless noted)
REQ-023 Stimulus: ExecuteRaw_n 1->0 and held.
  - Required: Execute=1 and ExecutePulse=1 at edge 6.
  - Required: ExecutePulse=0 at edge 7.
  - Required: Execute stays 1.
REQ-024 Stimulus: ExecuteRaw_n low for 3 cycles, high for 1, then low and held.
  - Required: no output change during the bounce.
  - Required: Execute=1 six edges after the final falling edge is sampled.
REQ-025 Stimulus: SwRaw=8'hC5, Execute low, then Execute asserted, then SwRaw=8'h3A.
  - Required: mand=8'hC5 at edge 3.
  - Required: mand stays 8'hC5 while Execute=1.
  - Required: mand=8'h3A three edges after Execute returns to 0.
REQ-026 Stimulus: both keys pressed in the same cycle.
  - Required: Execute, ClearA_loadB, ExecutePulse and ClearPulse all assert together at edge 6.
REQ-027 Stimulus: Reset pulsed mid-clock at counter value 3 with the key held.
  - Required: all outputs 0 asynchronously.
  - Required: after release, Execute=1 with a pulse 6 edges later.
REQ-028 Stimulus: INPUT_CONDITIONER_DEBOUNCE_EN undefined, ClearA_loadBRaw_n 1->0.
  - Required: ClearA_loadB=1 and ClearPulse=1 at edge 2.
